// File: rtl/lsu_bus_master.sv
// Load/store unit bus master: one RV32I access at a time against a single-cycle word memory.
// Sub-word stores (SB/SH via read-modify-write) are built only when LSU_SUBWORD_STORE_EN is defined.
module lsu_bus_master #(
    parameter int DM_AW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       wdata_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              dm_we,
    output logic [DM_AW-1:0]  dm_addr,
    output logic [31:0]       dm_wd,
    input  logic [31:0]       dm_rd,
    output logic [2:0]        fsm_state
);
    // Handshake: req is taken only while busy=0; done (and err) pulse for exactly one cycle.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
`ifdef LSU_SUBWORD_STORE_EN
    localparam logic [2:0] S_RMW_RD = 3'd2;
`endif
    localparam logic [2:0] S_STORE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]       state;
    logic [2:0]       next_req;
    logic             illegal;
    logic [2:0]       f3_q;
    logic [DM_AW+1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      load_val;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      store_word;
    logic             unused_addr_hi;

    assign unused_addr_hi = ^addr_in[31:DM_AW+2];

    always_comb begin
        illegal = 1'b0;
        case (funct3)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = addr_in[0];
            3'b010:  illegal = (addr_in[1:0] != 2'b00);
            3'b100:  illegal = store;
            3'b101:  illegal = store | addr_in[0];
            default: illegal = 1'b1;
        endcase
`ifndef LSU_SUBWORD_STORE_EN
        if (store && (funct3 == 3'b000 || funct3 == 3'b001))
            illegal = 1'b1;
`endif
    end

    always_comb begin
        next_req = S_LOAD;
        if (illegal)
            next_req = S_ERR;
        else if (store && funct3 == 3'b010)
            next_req = S_STORE;
`ifdef LSU_SUBWORD_STORE_EN
        else if (store)
            next_req = S_RMW_RD;
`endif
    end

    // Little-endian lane selection from the latched byte offset.
    always_comb begin
        ld_byte = dm_rd[8*addr_q[1:0] +: 8];
        ld_half = addr_q[1] ? dm_rd[31:16] : dm_rd[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = dm_rd;
        endcase
    end

`ifdef LSU_SUBWORD_STORE_EN
    logic [31:0] merge_q;
    logic [31:0] merged;

    always_comb begin
        merged = dm_rd;
        if (f3_q[0])
            merged[16*addr_q[1] +: 16] = wdata_q[15:0];
        else
            merged[8*addr_q[1:0] +: 8] = wdata_q[7:0];
    end

    assign store_word = (f3_q == 3'b010) ? wdata_q : merge_q;
`else
    assign store_word = wdata_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata   <= 32'd0;
`ifdef LSU_SUBWORD_STORE_EN
            merge_q <= 32'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        f3_q    <= funct3;
                        addr_q  <= addr_in[DM_AW+1:0];
                        wdata_q <= wdata_in;
                        state   <= next_req;
                    end
                end
                S_LOAD: begin
                    rdata <= load_val;
                    state <= S_DONE;
                end
`ifdef LSU_SUBWORD_STORE_EN
                S_RMW_RD: begin
                    merge_q <= merged;
                    state   <= S_STORE;
                end
`endif
                S_STORE: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE) || (state == S_ERR);
    assign err       = (state == S_ERR);
    assign dm_we     = (state == S_STORE);
    assign dm_wd     = (state == S_STORE) ? store_word : 32'd0;
    assign dm_addr   = addr_q[DM_AW+1:2];
    assign fsm_state = state;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master with a behavioural word memory on the dm_* port.
// Sub-word store expectations follow whether LSU_SUBWORD_STORE_EN is defined.
module tb_lsu_bus_master;
    localparam int DM_AW = 16;

    logic             clk;
    logic             rst_n;
    logic             req;
    logic             store;
    logic [2:0]       funct3;
    logic [31:0]      addr_in;
    logic [31:0]      wdata_in;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      rdata;
    logic             dm_we;
    logic [DM_AW-1:0] dm_addr;
    logic [31:0]      dm_wd;
    logic [31:0]      dm_rd;
    logic [2:0]       fsm_state;

    logic [31:0] mem [0:(1<<DM_AW)-1];
    logic [31:0] exp_q[$];

    int tests_run;
    int tests_failed;
    int we_total;

    int          done_cyc, err_cyc, we_cyc, we_cnt, done_cnt;
    logic [31:0] we_addr, we_data;
    logic [31:0] last_rd;
    int          we_snap;

    lsu_bus_master #(.DM_AW(DM_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .store     (store),
        .funct3    (funct3),
        .addr_in   (addr_in),
        .wdata_in  (wdata_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wd     (dm_wd),
        .dm_rd     (dm_rd),
        .fsm_state (fsm_state)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rd = mem[dm_addr];

    always @(posedge clk) begin
        if (dm_we === 1'b1) begin
            mem[dm_addr] <= dm_wd;
            we_total     <= we_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one access at cycle N and records what happens over cycles N+1..N+6.
    task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input bit poke);
        done_cyc = 0; err_cyc = 0; we_cyc = 0; we_cnt = 0; done_cnt = 0;
        we_addr = 32'd0; we_data = 32'd0;
        @(negedge clk);
        req = 1'b1; store = st; funct3 = f3; addr_in = a; wdata_in = wd;
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = k;
            end
            if (err === 1'b1 && err_cyc == 0) err_cyc = k;
            if (dm_we === 1'b1) begin
                we_cnt++;
                we_cyc  = k;
                we_addr = 32'(dm_addr);
                we_data = dm_wd;
            end
            if (poke && k == 1) begin
                req = 1'b1; store = 1'b1; funct3 = 3'b010;
                addr_in = 32'h14; wdata_in = 32'h5555_5555;
            end
            if (poke && k == 2) req = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_error(input string tag);
        check({tag, "_err_cyc"},  32'(err_cyc), 32'd1);
        check({tag, "_done_cyc"}, 32'(done_cyc), 32'd1);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_we_cnt"},   32'(we_cnt), 32'd0);
        check({tag, "_rdata"},    rdata, last_rd);
    endtask

    logic [2:0]  ld_f3   [7] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b010, 3'b101, 3'b100};
    logic [31:0] ld_addr [7] = '{32'h0D, 32'h0E, 32'h0E, 32'h0E, 32'h0C, 32'h0C, 32'h0F};
    logic [31:0] ld_exp  [7] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF,
                                 32'h80FF_7F01, 32'h0000_7F01, 32'h0000_0080};

    initial begin
        tests_run = 0; tests_failed = 0; we_total = 0;
        last_rd = 32'd0;
        rst_n = 1'b0; req = 1'b0; store = 1'b0; funct3 = 3'b000;
        addr_in = 32'd0; wdata_in = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[3] = 32'h80FF_7F01;
        mem[5] = 32'h1111_1111;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_err",     32'(err),     32'd0);
        check("rst_dm_we",   32'(dm_we),   32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_dm_addr", 32'(dm_addr), 32'd0);
        check("rst_dm_wd",   dm_wd,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // loads from word 3
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(ld_exp[i]);
            run_access(1'b0, ld_f3[i], ld_addr[i], 32'd0, 1'b0);
            last_rd = exp_q.pop_front();
            check($sformatf("load%0d_rdata", i), rdata, last_rd);
            check($sformatf("load%0d_done_cyc", i), 32'(done_cyc), 32'd2);
            check($sformatf("load%0d_err", i), 32'(err_cyc), 32'd0);
            check($sformatf("load%0d_we_cnt", i), 32'(we_cnt), 32'd0);
        end

        // SW to word 30
        run_access(1'b1, 3'b010, 32'h78, 32'hDEAD_BEEF, 1'b0);
        check("sw_we_cyc",   32'(we_cyc),   32'd1);
        check("sw_we_cnt",   32'(we_cnt),   32'd1);
        check("sw_we_addr",  we_addr,       32'd30);
        check("sw_we_data",  we_data,       32'hDEAD_BEEF);
        check("sw_done_cyc", 32'(done_cyc), 32'd2);
        check("sw_err",      32'(err_cyc),  32'd0);
        check("sw_mem30",    mem[30],       32'hDEAD_BEEF);
        check("sw_rdata",    rdata,         last_rd);

        // SB 0x0D
        run_access(1'b1, 3'b000, 32'h0D, 32'h0000_00AA, 1'b0);
`ifdef LSU_SUBWORD_STORE_EN
        check("sb_we_cyc",   32'(we_cyc),   32'd2);
        check("sb_we_cnt",   32'(we_cnt),   32'd1);
        check("sb_we_addr",  we_addr,       32'd3);
        check("sb_done_cyc", 32'(done_cyc), 32'd3);
        check("sb_mem3",     mem[3],        32'h80FF_AA01);
        check("sb_rdata",    rdata,         last_rd);
`else
        check_error("sb");
        check("sb_mem3",     mem[3],        32'h80FF_7F01);
`endif

        // SH 0x0E
        mem[3] = 32'h80FF_7F01;
        run_access(1'b1, 3'b001, 32'h0E, 32'h0000_1234, 1'b0);
`ifdef LSU_SUBWORD_STORE_EN
        check("sh_we_cyc",   32'(we_cyc),   32'd2);
        check("sh_we_cnt",   32'(we_cnt),   32'd1);
        check("sh_done_cyc", 32'(done_cyc), 32'd3);
        check("sh_mem3",     mem[3],        32'h1234_7F01);
`else
        check_error("sh");
        check("sh_mem3",     mem[3],        32'h80FF_7F01);
`endif

        // illegal accesses
        run_access(1'b0, 3'b010, 32'h06, 32'd0, 1'b0);
        check_error("lw_mis");
        run_access(1'b0, 3'b001, 32'h03, 32'd0, 1'b0);
        check_error("lh_mis");
        run_access(1'b0, 3'b011, 32'h0C, 32'd0, 1'b0);
        check_error("f3_011");
        run_access(1'b1, 3'b100, 32'h0C, 32'h0000_0077, 1'b0);
        check_error("sbu");

        // req pulse while busy is dropped
        mem[3] = 32'h80FF_7F01;
        run_access(1'b0, 3'b010, 32'h0C, 32'd0, 1'b1);
        last_rd = 32'h80FF_7F01;
        check("poke_rdata",    rdata,         last_rd);
        check("poke_done_cyc", 32'(done_cyc), 32'd2);
        check("poke_we_cnt",   32'(we_cnt),   32'd0);
        check("poke_mem5",     mem[5],        32'h1111_1111);
        check("poke_busy",     32'(busy),     32'd0);

        // reset in the cycle after an SB request
        mem[3] = 32'h80FF_7F01;
        @(negedge clk);
        req = 1'b1; store = 1'b1; funct3 = 3'b000; addr_in = 32'h0D; wdata_in = 32'h0000_00AA;
        @(posedge clk); #1;
        req = 1'b0;
        check("abort_busy_pre", 32'(busy), 32'd1);
        we_snap = we_total;
        rst_n = 1'b0;
        #1;
        check("abort_busy",    32'(busy),    32'd0);
        check("abort_done",    32'(done),    32'd0);
        check("abort_err",     32'(err),     32'd0);
        check("abort_dm_we",   32'(dm_we),   32'd0);
        check("abort_rdata",   rdata,        32'd0);
        check("abort_dm_addr", 32'(dm_addr), 32'd0);
        check("abort_dm_wd",   dm_wd,        32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_we_total", 32'(we_total), 32'(we_snap));
        check("abort_mem3",     mem[3],        32'h80FF_7F01);
        check("abort_idle",     32'(busy),     32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lsu_bus_master.md
LSU_BUS_MASTER -- requirements
Module: lsu_bus_master

Interface
REQ-001 Parameter: DM_AW, 16, width of the word address driven to the data memory.
REQ-002 clk  in  1  single system clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req  in  1  core access request; sampled only in IDLE.
REQ-005 store  in  1  1 = store, 0 = load; latched with req.
REQ-006 funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr_in  in  32  byte address from core.
REQ-008 wdata_in  in  32  store data, right-aligned.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  one-cycle pulse: misaligned or illegal access, no memory effect.
REQ-012 rdata  out  32  registered, extended load result.
REQ-013 dm_we  out  1  word write enable to data memory.
REQ-014 dm_addr  out  DM_AW  word address = addr_in[DM_AW+1:2] (latched); upper bits ignored, wrap.
REQ-015 dm_wd  out  32  word write data.
REQ-016 dm_rd  in  32  combinational word read data from data memory, same cycle as dm_addr.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RMW_RD, STORE, DONE, ERR.
REQ-018 IDLE + req: latch store, funct3, addr_in, wdata_in; next = ERR if illegal, else LOAD (load), STORE (SW), RMW_RD (SB/SH).
REQ-019 Illegal: funct3 in {011,110,111}, funct3 100/101 with store=1, H/HU with addr[0]=1, W with addr[1:0]!=00.
REQ-020 LOAD: sample dm_rd, select byte/half by addr[1:0] (little-endian), sign-extend for B/H, zero-extend for BU/HU, write rdata; next DONE.
REQ-021 RMW_RD: sample dm_rd into merge register, replace addressed byte/half with wdata_in low bits; next STORE.
REQ-022 STORE: dm_we=1 exactly this one cycle, dm_wd = wdata (SW) or merged word; next DONE.
REQ-023 DONE: done=1 one cycle; next IDLE. ERR: err=1 and done=1 one cycle; next IDLE.
REQ-024 Latency from req cycle N: load done at N+2; SW done at N+2; SB/SH done at N+3; error at N+1.
REQ-025 req outside IDLE SHALL be ignored (no queueing); core must hold/reissue.
REQ-026 rdata SHALL change only on load completion; stores and errors leave it unchanged.
REQ-027 dm_we SHALL be 0 in all states other than STORE; dm_addr stays stable from LOAD/RMW_RD through STORE.
REQ-028 No special casing of memory-mapped words (29 key, 30/31 LEDs); accesses to them behave as ordinary RAM words.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, busy=0, done=0, err=0, dm_we=0, rdata=0, dm_addr=0, dm_wd=0.
REQ-030 Reset during RMW_RD or STORE SHALL abort with no further dm_we; access is not retried after release.

Configuration
REQ-031 Macro LSU_SUBWORD_STORE_EN defined: SB/SH supported via RMW_RD per REQ-021.
REQ-032 Macro not defined: SB/SH classed illegal (ERR at N+1, no dm_we); RMW_RD and merge logic absent; loads unaffected.

Verification
REQ-033 DM word 3 = 0x80FF7F01; LB 0x0D -> rdata 0x0000007F, LB 0x0E -> 0xFFFFFFFF, LBU 0x0E -> 0x000000FF, LH 0x0E -> 0xFFFF80FF, done at N+2.
REQ-034 Word 3 = 0x80FF7F01; SB 0x0D data 0x000000AA -> single dm_we at N+2, word 3 = 0x80FFAA01, done N+3.
REQ-035 Word 3 = 0x80FF7F01; SH 0x0E data 0x00001234 -> word 3 = 0x12347F01; without LSU_SUBWORD_STORE_EN -> err N+1, word unchanged.
REQ-036 SW 0x78 data 0xDEADBEEF -> dm_addr 30, dm_wd 0xDEADBEEF, dm_we at N+1 only, done N+2.
REQ-037 LW 0x06 and LH 0x03 -> err and done at N+1, no dm_we, rdata unchanged; req pulses while busy -> ignored.
REQ-038 rst_n low during RMW_RD of SB -> dm_we never asserted, all outputs 0 same cycle, IDLE after release.
